// File: rtl/mem_map_pkg.sv
// Shared memory map for the data-memory bus: MMIO addresses, STATUS bit
// positions and the register selector used by the responder decode.
package mem_map_pkg;

   localparam logic [31:0] MMIO_BASE     = 32'hFFFF_FF00;
   localparam logic [31:0] OUT_DATA_ADDR = 32'hFFFF_FF00;
   localparam logic [31:0] STATUS_ADDR   = 32'hFFFF_FF01;
   localparam logic [31:0] CYCLE_ADDR    = 32'hFFFF_FF02;
   localparam logic [31:0] COUNT_ADDR    = 32'hFFFF_FF03;

   localparam int ST_EMPTY    = 0;
   localparam int ST_FULL     = 1;
   localparam int ST_OVERFLOW = 2;

   // Low two address bits pick one of the four MMIO registers
   typedef enum logic [1:0] {
      REG_OUT_DATA = 2'd0,
      REG_STATUS   = 2'd1,
      REG_CYCLE    = 2'd2,
      REG_COUNT    = 2'd3
   } mmio_reg_e;

   function automatic logic is_mmio(input logic [31:0] addr);
      return addr[31:2] == MMIO_BASE[31:2];
   endfunction

endpackage

// File: rtl/out_fifo.sv
// Synchronous output-word FIFO: push side from the bus, valid/ready drain
// side to the external consumer. No bypass; head word is registered storage.
module out_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   output logic                     full,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      occ;
   logic             do_push;
   logic             do_pop;

   assign out_valid = (occ != '0);
   assign full      = (occ == (PW+1)'(DEPTH));
   assign do_pop    = out_valid && out_ready;
   // A push into a full FIFO still lands when the head leaves on the same edge
   assign do_push   = push && (!full || do_pop);
   assign count     = occ;
   assign out_data  = out_valid ? store[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (do_push)
         store[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory responder for the single-cycle core: word RAM, MMIO output
// FIFO, sticky overflow flag and free-running cycle counter. Reads are combinational.
module dmem_mmio
   import mem_map_pkg::*;
#(
   parameter int DATA_MEM_WORDS = 1024,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_writedata,
   output logic [31:0] mem_readdata,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam int AW = $clog2(DATA_MEM_WORDS);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]   ram [DATA_MEM_WORDS];
   logic          ram_sel;
   logic          mmio_sel;
   mmio_reg_e     reg_sel;
   logic [AW-1:0] ram_idx;

   logic          push_req;
   logic          ovf_set;
   logic          ovf_clr;
   logic          pop;
   logic          fifo_full;
   logic [CW-1:0] fifo_count;
   logic          overflow;
   logic [31:0]   cycle_cnt;

   assign ram_sel  = mem_addr < 32'(DATA_MEM_WORDS);
   assign mmio_sel = is_mmio(mem_addr);
   assign reg_sel  = mmio_reg_e'(mem_addr[1:0]);
   assign ram_idx  = mem_addr[AW-1:0];

   assign push_req = memwrite && mmio_sel && (reg_sel == REG_OUT_DATA);
   assign ovf_clr  = memwrite && mmio_sel && (reg_sel == REG_STATUS)
                     && mem_writedata[ST_OVERFLOW];
   assign pop      = out_valid && out_ready;
   // Dropped push: full and the head is not leaving this edge
   assign ovf_set  = push_req && fifo_full && !pop;

   out_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_out_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_req),
      .push_data (mem_writedata),
      .full      (fifo_full),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (fifo_count)
   );

   // RAM contents survive reset, but a write coinciding with reset is dropped
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
      end else if (memwrite && ram_sel) begin
         ram[ram_idx] <= mem_writedata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_cnt <= '0;
         overflow  <= 1'b0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (ovf_set)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;
      end
   end

   always_comb begin
      mem_readdata = '0;
      if (memread) begin
         if (ram_sel) begin
            mem_readdata = ram[ram_idx];
         end else if (mmio_sel) begin
            case (reg_sel)
               REG_STATUS: begin
                  mem_readdata[ST_OVERFLOW] = overflow;
                  mem_readdata[ST_FULL]     = fifo_full;
                  mem_readdata[ST_EMPTY]    = !out_valid;
               end
               REG_CYCLE:  mem_readdata = cycle_cnt;
               REG_COUNT:  mem_readdata = 32'(fifo_count);
               default:    mem_readdata = '0;
            endcase
         end
      end
   end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Responder side of the CPU data-memory bus: services `memread`/`memwrite` at `mem_addr` with a word-addressed data RAM plus a small memory-mapped I/O region. The I/O region holds an output-word FIFO drained by an external consumer over valid/ready, a sticky overflow flag, and a free-running cycle counter. It sits beside the single-cycle CPU core. Reads are combinational, as the core requires. Writes commit on the clock edge.

## Interface
Parameters:
- DATA_MEM_WORDS, 1024, RAM depth in 32-bit words; must be a power of 2.
- FIFO_DEPTH, 4, output FIFO depth in words; must be a power of 2 and ≥2.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- memread  in  1  read request, same-cycle.
- memwrite  in  1  write request, committed at the next rising edge.
- mem_addr  in  32  word address; not a byte address.
- mem_writedata  in  32  write data.
- mem_readdata  out  32  combinational read data.
- out_data  out  32  FIFO head word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head word on a rising edge where out_valid=1.

## Operation
Address decode:
- `mem_addr < DATA_MEM_WORDS` selects the RAM at index `mem_addr[log2(DATA_MEM_WORDS)-1:0]`.
- `mem_addr` in 0xFFFF_FF00..0xFFFF_FF03 selects the MMIO registers below.
- Any other address is unmapped: reads return 0, writes are ignored.

MMIO registers:
- 0xFFFF_FF00 OUT_DATA.
  - Write: push mem_writedata into the FIFO. If the FIFO is full and no pop occurs that cycle, the word is dropped and OVERFLOW is set.
  - Read: returns 0.
- 0xFFFF_FF01 STATUS. Read returns {29'b0, OVERFLOW, full, empty}. Writing 1 to bit 2 clears OVERFLOW; other bits are ignored.
- 0xFFFF_FF02 CYCLE. Read returns the 32-bit cycle counter. Writes are ignored.
- 0xFFFF_FF03 COUNT. Read returns the FIFO occupancy, zero-extended to 32 bits.

Bus rules:
- mem_readdata = 0 whenever memread=0.
- memread and memwrite both high: the write is performed, and mem_readdata shows the pre-write value.

Cycle counter:
- Cleared by reset.
- Increments by 1 on every rising edge while reset=0.
- Wraps from 0xFFFF_FFFF to 0.

FIFO:
- Push and pop in the same cycle with the FIFO full: both occur and occupancy is unchanged.
- Push and pop in the same cycle with the FIFO empty: pop is impossible because out_valid=0, so only the push occurs.
- No bypass: a word pushed into an empty FIFO appears on out_valid one cycle later.
- Pointers wrap modulo FIFO_DEPTH.
- Occupancy is a separate counter of width log2(FIFO_DEPTH)+1, so a full FIFO is distinguishable from an empty one.

OVERFLOW:
- Set-and-clear in the same cycle (a dropped push while a STATUS clear write is in progress) is impossible, since only one bus access occurs per cycle.
- A set on a dropped push takes effect at that edge.

## Timing
Reset values:
- mem_readdata follows the decode (0 when memread=0).
- out_valid=0, out_data=0, OVERFLOW=0, counter=0, FIFO pointers and occupancy = 0.
- RAM contents are not reset.

Reset behaviour:
- Assertion mid-operation immediately empties the FIFO and clears OVERFLOW and the counter.
- An in-flight write is lost.

Latencies:
- Read: 0 cycles, combinational from mem_addr/memread. A RAM word written at edge N reads back its new value in cycle N+1. A read in the same cycle as the write returns the old value.
- FIFO: push at edge N gives out_valid=1 in cycle N+1. A pop at edge N updates out_data/out_valid in cycle N+1.
- out_data must hold stable while out_valid=1 and out_ready=0.
- STATUS and COUNT reflect registered state, i.e. the values before the current cycle's push/pop.

## Structure
- Package `mem_map_pkg`:
  - address constants (MMIO_BASE, OUT_DATA_ADDR, STATUS_ADDR, CYCLE_ADDR, COUNT_ADDR);
  - STATUS bit indices (ST_EMPTY=0, ST_FULL=1, ST_OVERFLOW=2).
  - The CPU-side software headers use the same values.
- Sub-module `out_fifo`: synchronous FIFO with async reset, parameterised on WIDTH and DEPTH, with push/full and valid/ready ports plus count.
- The top level holds the RAM, address decode, read mux, cycle counter and OVERFLOW.

## Test plan
- Reset, then write 0xDEADBEEF to address 5 and read address 5 next cycle. Expect 0xDEADBEEF. A same-cycle read during the write returns the prior value.
- With out_ready=0, push 0x11, 0x22, 0x33, 0x44, 0x55 to 0xFFFF_FF00.
  - COUNT reads 4 and STATUS reads 0x2 before the fifth push.
  - After the fifth push, STATUS = 0x6 and 0x55 is absent.
  - Write 0x4 to STATUS, then STATUS = 0x2.
- With the FIFO full, push while out_ready=1 on the same edge. Expect no OVERFLOW, COUNT stays 4, and the drain order is 0x11, 0x22, 0x33, 0x44, then the new word.
- Release reset, then read CYCLE at cycles 0 and 10. Expect 0 and 10. Force the counter near 0xFFFF_FFFE via long run or force. Expect the wrap to 0.
- Read 0x0000_4000 and 0xFFFF_FF07. Expect 0. Writes to those addresses change no state.
- Assert reset asynchronously mid-cycle with 3 words queued. Expect out_valid=0 and COUNT=0 immediately, and CYCLE=0.
